// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store sequencer between the control unit and a
// single-beat memory port.
//
// A one-cycle start in IDLE samples is_store/funct3/addr/wdata. Legal,
// aligned requests drive a registered memory request until mem_ack; the
// returned word is lane-selected and sign/zero-extended into rdata. Illegal
// or misaligned requests skip memory and complete with err=1.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle request (honoured only in IDLE)
//   is_store, funct3      operation and RISC-V size/sign code
//   addr, wdata           byte address, store data
//   busy                  high whenever not IDLE
//   done, err             one-cycle completion pulse, fault flag
//   rdata                 extended load result (0 for stores and faults)
//   mem_req, mem_we       registered memory request / write enable
//   mem_be, mem_addr      byte enables, word-aligned address
//   mem_wdata             lane-replicated store data
//   mem_ack, mem_rdata    single-cycle completion and read word
//
// Build option
//   MEM_TIMEOUT_EN        when defined, an ACCESS that sees no mem_ack for
//                         TIMEOUT_CYCLES cycles is aborted with err=1.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start
// ACCESS | mem_req held, waiting for mem_ack (or timeout)
// RESP   | one-cycle done pulse, err reports any fault

module lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [2:0]  f3_q, f3_nx;
   logic [1:0]  off_q, off_nx;
   logic        req_nx, we_nx, done_nx, err_nx;
   logic [3:0]  be_nx;
   logic [31:0] addr_nx, wd_nx, rdata_nx;

   logic        legal_op, aligned;
   logic [3:0]  be_dec;
   logic [31:0] wd_dec;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_ext;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nx;
   logic             tmo_hit;
   assign tmo_hit = (tmo_cnt == '0);
`endif

   assign busy = (state != IDLE);

   // request decode on the live inputs (only used when start is accepted)
   always_comb begin
      legal_op = 1'b0;
      aligned  = 1'b0;
      be_dec   = 4'b1111;
      wd_dec   = wdata;
      case (funct3)
         3'b000, 3'b001, 3'b010: legal_op = 1'b1;
         3'b100, 3'b101:         legal_op = !is_store;
         default:                legal_op = 1'b0;
      endcase
      case (funct3[1:0])
         2'b00: begin
            aligned = 1'b1;
            be_dec  = 4'b0001 << addr[1:0];
            wd_dec  = {4{wdata[7:0]}};
         end
         2'b01: begin
            aligned = !addr[0];
            be_dec  = addr[1] ? 4'b1100 : 4'b0011;
            wd_dec  = {2{wdata[15:0]}};
         end
         2'b10: begin
            aligned = (addr[1:0] == 2'b00);
            be_dec  = 4'b1111;
            wd_dec  = wdata;
         end
         default: aligned = 1'b0;
      endcase
   end

   // lane extraction uses the size code and byte offset captured at start
   always_comb begin
      lane_b = 8'h00;
      case (off_q)
         2'd0: lane_b = mem_rdata[7:0];
         2'd1: lane_b = mem_rdata[15:8];
         2'd2: lane_b = mem_rdata[23:16];
         default: lane_b = mem_rdata[31:24];
      endcase
      lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_ext = {24'h0, lane_b};
         3'b101:  load_ext = {16'h0, lane_h};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      req_nx   = mem_req;
      we_nx    = mem_we;
      be_nx    = mem_be;
      addr_nx  = mem_addr;
      wd_nx    = mem_wdata;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      rdata_nx = rdata;
      f3_nx    = f3_q;
      off_nx   = off_q;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_nx = tmo_cnt;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               rdata_nx = 32'h0;
               f3_nx    = funct3;
               off_nx   = addr[1:0];
               if (legal_op && aligned) begin
                  state_nx = ACCESS;
                  req_nx   = 1'b1;
                  we_nx    = is_store;
                  be_nx    = be_dec;
                  addr_nx  = {addr[31:2], 2'b00};
                  wd_nx    = wd_dec;
`ifdef MEM_TIMEOUT_EN
                  tmo_cnt_nx = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
               end else begin
                  state_nx = RESP;
                  done_nx  = 1'b1;
                  err_nx   = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_nx = RESP;
               req_nx   = 1'b0;
               done_nx  = 1'b1;
               rdata_nx = mem_we ? 32'h0 : load_ext;
            end
`ifdef MEM_TIMEOUT_EN
            // ack on the final counted cycle still wins over the abort
            else if (tmo_hit) begin
               state_nx = RESP;
               req_nx   = 1'b0;
               done_nx  = 1'b1;
               err_nx   = 1'b1;
               rdata_nx = 32'h0;
            end else begin
               tmo_cnt_nx = tmo_cnt - 1'b1;
            end
`endif
         end
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'h0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'h0;
         f3_q      <= 3'h0;
         off_q     <= 2'h0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         state     <= state_nx;
         mem_req   <= req_nx;
         mem_we    <= we_nx;
         mem_be    <= be_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wd_nx;
         done      <= done_nx;
         err       <= err_nx;
         rdata     <= rdata_nx;
         f3_q      <= f3_nx;
         off_q     <= off_nx;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_nx;
`endif
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// transactions, compared every cycle against a transaction-level model.
module tb_lsu_ctrl;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
      .funct3(funct3), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // expected outputs for the current cycle, maintained by the driver
   logic        e_busy = 0, e_done = 0, e_err = 0, e_req = 0, e_we = 0;
   logic [3:0]  e_be = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;

   int          req_rises = 0;
   logic        req_d = 1'b0;
   int          nsteps, obs_done_step;
   logic        obs_err;
   logic        cap_we;
   logic [3:0]  cap_be;
   logic [31:0] cap_addr, cap_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      chk("busy", {31'h0, busy}, {31'h0, e_busy});
      chk("done", {31'h0, done}, {31'h0, e_done});
      chk("err", {31'h0, err}, {31'h0, e_err});
      chk("mem_req", {31'h0, mem_req}, {31'h0, e_req});
      if (e_req) begin
         chk("mem_we", {31'h0, mem_we}, {31'h0, e_we});
         chk("mem_be", {28'h0, mem_be}, {28'h0, e_be});
         chk("mem_addr", mem_addr, e_addr);
         if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (!e_busy || e_done) chk("rdata", rdata, e_rdata);
      if (mem_req === 1'b1 && req_d !== 1'b1) req_rises++;
      req_d = mem_req;
   end

   // ---------------- behavioural model ----------------
   function automatic bit m_ok(input bit st, input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0: return 1'b1;
         3'd1: return a[0] == 1'b0;
         3'd2: return a[1:0] == 2'b00;
         3'd4: return !st;
         3'd5: return !st && (a[0] == 1'b0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int first, bytes;
      logic [3:0] be;
      bytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
      first = (bytes == 1) ? int'(a[1:0]) : (bytes == 2) ? 2 * int'(a[1]) : 0;
      be = 4'h0;
      for (int i = 0; i < 4; i++) if (i >= first && i < first + bytes) be[i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] w);
      logic [31:0] r;
      r = w;
      if (f3 == 3'd0) for (int i = 0; i < 4; i++) r[8*i +: 8] = w[7:0];
      if (f3 == 3'd1) for (int i = 0; i < 2; i++) r[16*i +: 16] = w[15:0];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * int'(a[1:0]))) & 32'hFF;
      h = (word >> (16 * int'(a[1]))) & 32'hFFFF;
      case (f3)
         3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
         3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'd4: return b;
         3'd5: return h;
         default: return word;
      endcase
   endfunction

   // ---------------- driver ----------------
   task automatic tstep();
      @(posedge clk);
      #1;
      nsteps++;
      if (done === 1'b1 && obs_done_step == 0) begin
         obs_done_step = nsteps;
         obs_err = err;
      end
   endtask

   task automatic resp_exit(input bit junk);
      if (junk) begin
         start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = $urandom & 32'hFFFF_FFFC;
         mem_ack = 1'($urandom);
      end
      tstep();
      start = 1'b0; mem_ack = 1'b0;
      e_busy = 0; e_done = 0; e_err = 0; e_req = 0;
   endtask

   task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w, input int delay, input logic [31:0] word,
                         input bit junk);
      bit ok;
      logic [31:0] res;
      ok = m_ok(st, f3, a);
      res = st ? 32'h0 : m_load(f3, a, word);
      nsteps = 0; obs_done_step = 0; obs_err = 1'b0;
      start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = w;
      tstep();
      start = 1'b0;
      cap_we = mem_we; cap_be = mem_be; cap_addr = mem_addr; cap_wdata = mem_wdata;
      if (!ok) begin
         e_busy = 1; e_done = 1; e_err = 1; e_req = 0; e_rdata = 32'h0;
         resp_exit(1'($urandom));
         return;
      end
      e_busy = 1; e_done = 0; e_err = 0; e_req = 1; e_we = st;
      e_be = m_be(f3, a); e_addr = a & 32'hFFFF_FFFC; e_wdata = m_wd(f3, w);
      for (int k = 1; k <= 200; k++) begin
         if (k - 1 == delay) begin
            start = 1'b0; mem_ack = 1'b1; mem_rdata = word;
         end else begin
            mem_ack = 1'b0; mem_rdata = $urandom;
            start = junk ? 1'($urandom) : 1'b0;
            is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
         end
         tstep();
         if (k - 1 == delay) begin
            e_busy = 1; e_done = 1; e_err = 0; e_req = 0; e_rdata = res;
            break;
         end
`ifdef MEM_TIMEOUT_EN
         if (k == TO) begin
            e_busy = 1; e_done = 1; e_err = 1; e_req = 0; e_rdata = 32'h0;
            break;
         end
`endif
      end
      start = 1'b0; mem_ack = 1'b0;
      resp_exit(1'($urandom));
   endtask

   int r0;
   logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // LB, top byte lane, immediate ack
      do_txn(1'b0, 3'd0, 32'h1003, 32'h0, 0, 32'h80FF_FFFF, 1'b0);
      chk("lb_be", {28'h0, cap_be}, 32'h8);
      chk("lb_addr", cap_addr, 32'h1000);
      chk("lb_rdata", rdata, 32'hFFFF_FF80);
      chk("lb_latency", obs_done_step, 2);
      chk("lb_err", {31'h0, obs_err}, 32'h0);

      // SH upper half, ack delayed 5 cycles
      do_txn(1'b1, 3'd1, 32'h2002, 32'h1234_ABCD, 5, 32'h0, 1'b0);
      chk("sh_we", {31'h0, cap_we}, 32'h1);
      chk("sh_be", {28'h0, cap_be}, 32'hC);
      chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      chk("sh_latency", obs_done_step, 7);
      chk("sh_rdata", rdata, 32'h0);

      // misaligned LW and store-with-HU: no memory access
      r0 = req_rises;
      do_txn(1'b0, 3'd2, 32'h3001, 32'h0, 0, 32'h0, 1'b0);
      chk("lw_mis_latency", obs_done_step, 1);
      chk("lw_mis_err", {31'h0, obs_err}, 32'h1);
      do_txn(1'b1, 3'd5, 32'h4000, 32'h0, 0, 32'h0, 1'b0);
      chk("shu_ill_latency", obs_done_step, 1);
      chk("shu_ill_err", {31'h0, obs_err}, 32'h1);
      chk("fault_no_req", req_rises - r0, 0);

      // LHU with extra starts during ACCESS
      r0 = req_rises;
      do_txn(1'b0, 3'd5, 32'h4002, 32'h0, 3, 32'hBEEF_0000, 1'b1);
      chk("lhu_rdata", rdata, 32'h0000_BEEF);
      chk("lhu_single_req", req_rises - r0, 1);

      // long wait: timeout abort or indefinite wait depending on build
`ifdef MEM_TIMEOUT_EN
      do_txn(1'b0, 3'd2, 32'h5000, 32'h0, TO + 5, 32'h1111_2222, 1'b0);
      chk("tmo_latency", obs_done_step, TO + 1);
      chk("tmo_err", {31'h0, obs_err}, 32'h1);
      chk("tmo_rdata", rdata, 32'h0);
`else
      do_txn(1'b0, 3'd2, 32'h5000, 32'h0, 40, 32'h1111_2222, 1'b0);
      chk("long_latency", obs_done_step, 42);
      chk("long_err", {31'h0, obs_err}, 32'h0);
      chk("long_rdata", rdata, 32'h1111_2222);
`endif

      // async reset in the middle of ACCESS
      start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h6000; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0;
      e_busy = 1; e_req = 1; e_we = 1; e_be = 4'hF; e_addr = 32'h6000; e_wdata = 32'hDEAD_BEEF;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_req", {31'h0, mem_req}, 32'h0);
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rst_be", {28'h0, mem_be}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_done_err", {30'h0, done, err}, 32'h0);
      e_busy = 0; e_done = 0; e_err = 0; e_req = 0; e_we = 0; e_rdata = 32'h0;
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(posedge clk); #1;

      // randomized traffic
      for (int t = 0; t < 300; t++) begin
         bit st;
         logic [2:0] f3;
         int dly;
         st = 1'($urandom);
         f3 = ($urandom_range(0, 7) < 7) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
         dly = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 22) : $urandom_range(0, 6);
         do_txn(st, f3, $urandom, $urandom, dly, $urandom, 1'($urandom));
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            mem_ack = 1'($urandom);
            @(posedge clk); #1;
         end
         mem_ack = 1'b0;
      end

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
